uart_tx_packet_sender: RTL and testbench

//  Parametrised multi-byte UART transmitter: latches a packet of up to MAX_BYTES bytes plus a

---
 rtl/uart_tx_packet_sender_pkg.sv | 32 +++
 rtl/uart_tx_packet_sender_uart_tx.sv | 74 +++++++
 rtl/uart_tx_packet_sender.sv | 124 ++++++++++++
 tb/tb_uart_tx_packet_sender.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_packet_sender_pkg.sv
// Shared definitions for the packet sender and its UART byte transmitter:
// state encodings, frame length and a constant-width helper.
package uart_tx_packet_sender_pkg;

  localparam int UART_FRAME_BITS = 10;

  typedef enum logic [2:0] {
    SENDER_IDLE,
    SENDER_LOAD,
    SENDER_WAIT_BYTE,
    SENDER_GAP,
    SENDER_DONE
  } senderState_t;

  typedef enum logic [0:0] {
    TX_IDLE,
    TX_SEND
  } txState_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_packet_sender_uart_tx.sv
// Single-byte 8N1 UART transmitter. Start, data and stop bits are shifted out
// of one frame register; o_txDone is high during the last stop-bit cycle.
module uart_tx
  import uart_tx_packet_sender_pkg::*;
#(
  parameter int CLOCK_SPEED = 1000000,
  parameter int BAUD_RATE   = 9600
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_txBegin,
  input  logic [7:0] i_txByte,
  output logic       o_txSerial,
  output logic       o_txDone
);

  localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
  localparam int CW = (clog2(CLKS_PER_BIT) > 0) ? clog2(CLKS_PER_BIT) : 1;
  localparam int BW = clog2(UART_FRAME_BITS);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_FRAME_BITS - 1);

  txState_t state;
  txState_t nextState;
  logic [CW-1:0] clkCount;
  logic [BW-1:0] bitCount;
  logic [UART_FRAME_BITS-1:0] frame;
  logic bitEnd;
  logic lastBit;

  assign bitEnd  = (clkCount == LAST_CLK);
  assign lastBit = bitEnd && (bitCount == LAST_BIT);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= TX_IDLE;
      clkCount <= '0;
      bitCount <= '0;
      frame    <= '1;
    end else begin
      state <= nextState;
      case (state)
        TX_IDLE: begin
          clkCount <= '0;
          bitCount <= '0;
          if (i_txBegin) frame <= {1'b1, i_txByte, 1'b0};
        end
        TX_SEND: begin
          if (bitEnd) begin
            clkCount <= '0;
            bitCount <= bitCount + BW'(1);
            frame    <= {1'b1, frame[UART_FRAME_BITS-1:1]};
          end else begin
            clkCount <= clkCount + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      TX_IDLE: if (i_txBegin) nextState = TX_SEND;
      TX_SEND: if (lastBit) nextState = TX_IDLE;
      default: nextState = TX_IDLE;
    endcase
  end

  assign o_txSerial = (state == TX_SEND) ? frame[0] : 1'b1;
  assign o_txDone   = (state == TX_SEND) && lastBit;

endmodule

// File: rtl/uart_tx_packet_sender.sv
// Multi-byte UART packet sender: latches up to MAX_BYTES bytes and streams them
// through one uart_tx with selectable byte order, inter-byte gap and abort.
module uart_tx_packet_sender
  import uart_tx_packet_sender_pkg::*;
#(
  parameter int CLOCK_SPEED = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int MAX_BYTES   = 14,
  parameter int MSB_FIRST   = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_txBegin,
  input  logic [8*MAX_BYTES-1:0] i_txData,
  input  logic [7:0]             i_txDataLength,
  input  logic                   i_abort,
  output logic                   o_txBusy,
  output logic                   o_txSerial,
  output logic                   o_txDone,
  output logic                   o_aborted,
  output logic                   o_lengthError,
  output logic [7:0]             o_bytesSent
);

  // The LOAD cycle is itself idle on the line, so GAP holds GAP_CYCLES-1 cycles.
  localparam logic [15:0] GAP_HOLD = 16'((GAP_CYCLES > 1) ? (GAP_CYCLES - 2) : 0);
  localparam logic [7:0]  MAX_LEN  = 8'(MAX_BYTES);

  senderState_t state;
  senderState_t nextState;
  logic [8*MAX_BYTES-1:0] dataReg;
  logic [7:0]  effLen;
  logic [7:0]  clampedLen;
  logic        abortLatch;
  logic        abortNow;
  logic        lastByte;
  logic [15:0] gapCount;
  logic [15:0] byteIndex;
  logic [15:0] byteShift;
  logic [7:0]  selectedByte;
  logic        uartBegin;
  logic        uartDone;

  assign clampedLen = (i_txDataLength > MAX_LEN) ? MAX_LEN : i_txDataLength;
  assign abortNow   = abortLatch | i_abort;
  assign lastByte   = (8'(o_bytesSent + 8'd1) == effLen);

  assign byteIndex    = (MSB_FIRST != 0) ? (16'(effLen) - 16'(o_bytesSent) - 16'd1)
                                         : 16'(o_bytesSent);
  assign byteShift    = {byteIndex[12:0], 3'b000};
  assign selectedByte = 8'(dataReg >> byteShift);
  assign uartBegin    = (state == SENDER_LOAD);

  uart_tx #(
    .CLOCK_SPEED(CLOCK_SPEED),
    .BAUD_RATE  (BAUD_RATE)
  ) uartTx (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_txBegin (uartBegin),
    .i_txByte  (selectedByte),
    .o_txSerial(o_txSerial),
    .o_txDone  (uartDone)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= SENDER_IDLE;
      dataReg       <= '0;
      effLen        <= '0;
      abortLatch    <= 1'b0;
      gapCount      <= '0;
      o_lengthError <= 1'b0;
      o_bytesSent   <= '0;
    end else begin
      state    <= nextState;
      gapCount <= (state == SENDER_GAP) ? gapCount + 16'd1 : 16'd0;
      if (state == SENDER_IDLE) begin
        if (i_txBegin) begin
          dataReg       <= i_txData;
          effLen        <= clampedLen;
          o_lengthError <= (i_txDataLength > MAX_LEN);
          o_bytesSent   <= '0;
          abortLatch    <= 1'b0;
        end
      end else if (state == SENDER_DONE) begin
        abortLatch <= 1'b0;
      end else begin
        if (i_abort) abortLatch <= 1'b1;
        if (state == SENDER_WAIT_BYTE && uartDone) o_bytesSent <= o_bytesSent + 8'd1;
      end
    end
  end

  // Bytes advance only on the uart_tx done pulse, never on a busy level.
  always_comb begin
    nextState = state;
    case (state)
      SENDER_IDLE: begin
        if (i_txBegin) nextState = (clampedLen == 8'd0) ? SENDER_DONE : SENDER_LOAD;
      end
      SENDER_LOAD: nextState = SENDER_WAIT_BYTE;
      SENDER_WAIT_BYTE: begin
        if (uartDone) begin
          if (lastByte || abortNow)  nextState = SENDER_DONE;
          else if (GAP_CYCLES > 1)   nextState = SENDER_GAP;
          else                       nextState = SENDER_LOAD;
        end
      end
      SENDER_GAP: begin
        if (abortNow)                   nextState = SENDER_DONE;
        else if (gapCount == GAP_HOLD)  nextState = SENDER_LOAD;
      end
      SENDER_DONE: nextState = SENDER_IDLE;
      default:     nextState = SENDER_IDLE;
    endcase
  end

  assign o_txBusy  = (state != SENDER_IDLE);
  assign o_txDone  = (state == SENDER_DONE);
  assign o_aborted = (state == SENDER_DONE) && abortLatch;

endmodule

// File: tb/tb_uart_tx_packet_sender.sv
// Scoreboard bench: two senders (MSB-first/no gap, LSB-first/20-cycle gap),
// line decoders and done monitors compare against a queue-based reference model.
module tb_uart_tx_packet_sender;

  localparam int MAX_BYTES = 14;

  typedef struct {
    int bytesSent;
    int aborted;
    int lengthError;
  } doneRec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  logic                   rst         [2];
  logic                   txBegin     [2];
  logic [8*MAX_BYTES-1:0] txData      [2];
  logic [7:0]             txLen       [2];
  logic                   abortIn     [2];
  logic                   busy        [2];
  logic                   serial      [2];
  logic                   txDone      [2];
  logic                   aborted     [2];
  logic                   lengthError [2];
  logic [7:0]             bytesSent   [2];

  int checks = 0;
  int errors = 0;
  int doneCount [2];

  logic [7:0] expFrames0 [$];
  logic [7:0] expFrames1 [$];
  doneRec_t   expDone0   [$];
  doneRec_t   expDone1   [$];
  int         starts0    [$];
  int         starts1    [$];

  uart_tx_packet_sender #(
    .CLOCK_SPEED(96000), .BAUD_RATE(9600), .MAX_BYTES(MAX_BYTES),
    .MSB_FIRST(1), .GAP_CYCLES(0)
  ) dut0 (
    .i_clock(clock), .i_reset(rst[0]), .i_txBegin(txBegin[0]), .i_txData(txData[0]),
    .i_txDataLength(txLen[0]), .i_abort(abortIn[0]), .o_txBusy(busy[0]),
    .o_txSerial(serial[0]), .o_txDone(txDone[0]), .o_aborted(aborted[0]),
    .o_lengthError(lengthError[0]), .o_bytesSent(bytesSent[0])
  );

  uart_tx_packet_sender #(
    .CLOCK_SPEED(96000), .BAUD_RATE(9600), .MAX_BYTES(MAX_BYTES),
    .MSB_FIRST(0), .GAP_CYCLES(20)
  ) dut1 (
    .i_clock(clock), .i_reset(rst[1]), .i_txBegin(txBegin[1]), .i_txData(txData[1]),
    .i_txDataLength(txLen[1]), .i_abort(abortIn[1]), .o_txBusy(busy[1]),
    .o_txSerial(serial[1]), .o_txDone(txDone[1]), .o_aborted(aborted[1]),
    .o_lengthError(lengthError[1]), .o_bytesSent(bytesSent[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, actual, actual, expected, expected, cycle);
    end
  endtask

  // Reference model: the k-th byte on the wire for a given packet and byte order.
  function automatic logic [7:0] refByte(input logic [8*MAX_BYTES-1:0] data, input int len,
                                         input int k, input bit msbFirst);
    int effLen;
    int pos;
    effLen = (len > MAX_BYTES) ? MAX_BYTES : len;
    pos    = msbFirst ? (effLen - 1 - k) : k;
    return data[8*pos +: 8];
  endfunction

  function automatic logic [8*MAX_BYTES-1:0] randomData();
    logic [8*MAX_BYTES-1:0] value;
    for (int i = 0; i < MAX_BYTES; i++) value[8*i +: 8] = 8'($urandom);
    return value;
  endfunction

  function automatic void flushInstance(input int idx);
    if (idx == 0) begin expFrames0.delete(); expDone0.delete(); end
    else          begin expFrames1.delete(); expDone1.delete(); end
  endfunction

  function automatic void pushExpected(input int idx, input logic [8*MAX_BYTES-1:0] data,
                                       input int len, input int abortAfter);
    doneRec_t rec;
    int effLen;
    int frames;
    effLen = (len > MAX_BYTES) ? MAX_BYTES : len;
    frames = (abortAfter < 0) ? effLen : abortAfter;
    for (int k = 0; k < frames; k++) begin
      if (idx == 0) expFrames0.push_back(refByte(data, len, k, 1'b1));
      else          expFrames1.push_back(refByte(data, len, k, 1'b0));
    end
    rec.bytesSent   = frames;
    rec.aborted     = (abortAfter >= 0) ? 1 : 0;
    rec.lengthError = (len > MAX_BYTES) ? 1 : 0;
    if (idx == 0) expDone0.push_back(rec);
    else          expDone1.push_back(rec);
  endfunction

  task automatic applyStimulus(input int idx, input logic [8*MAX_BYTES-1:0] data,
                               input int len, input int abortAfter);
    @(posedge clock); #1;
    txBegin[idx] = 1'b1;
    txData[idx]  = data;
    txLen[idx]   = 8'(len);
    pushExpected(idx, data, len, abortAfter);
    @(posedge clock); #1;
    txBegin[idx] = 1'b0;
    txData[idx]  = randomData();
    txLen[idx]   = 8'($urandom);
  endtask

  task automatic waitPackets(input int idx, input int count, input int budget);
    int target;
    target = doneCount[idx] + count;
    for (int c = 0; c < budget && doneCount[idx] < target; c++) @(posedge clock);
    checkOutput("packetCompletes", (doneCount[idx] >= target) ? 1 : 0, 1);
  endtask

  task automatic checkResetState(input int idx);
    @(negedge clock);
    checkOutput("resetBusy",        busy[idx],        0);
    checkOutput("resetSerial",      serial[idx],      1);
    checkOutput("resetDone",        txDone[idx],      0);
    checkOutput("resetAborted",     aborted[idx],     0);
    checkOutput("resetLengthError", lengthError[idx], 0);
    checkOutput("resetBytesSent",   bytesSent[idx],   0);
  endtask

  // Decodes 8N1 frames at mid-bit and compares against the expected frame queue.
  task automatic lineMonitor(input int idx);
    logic prevLine;
    logic [7:0] got;
    logic [7:0] want;
    logic startBit;
    logic stopBit;
    bit cut;
    bit haveWant;
    prevLine = 1'b1;
    forever begin
      @(negedge clock);
      if (serial[idx] === 1'b0 && prevLine === 1'b1 && rst[idx] === 1'b0) begin
        cut = 1'b0;
        got = '0;
        startBit = 1'b0;
        stopBit = 1'b0;
        if (idx == 0) starts0.push_back(cycle); else starts1.push_back(cycle);
        for (int c = 1; c <= 95; c++) begin
          @(negedge clock);
          if (rst[idx] !== 1'b0) cut = 1'b1;
          if (c == 5) startBit = serial[idx];
          if (c >= 15 && c <= 85 && ((c - 15) % 10) == 0) got[(c - 15) / 10] = serial[idx];
          if (c == 95) stopBit = serial[idx];
        end
        if (!cut) begin
          haveWant = 1'b0;
          want = '0;
          if (idx == 0 && expFrames0.size() > 0) begin want = expFrames0.pop_front(); haveWant = 1'b1; end
          if (idx == 1 && expFrames1.size() > 0) begin want = expFrames1.pop_front(); haveWant = 1'b1; end
          checkOutput("frameExpected", haveWant, 1);
          checkOutput("frameStartBit", startBit, 0);
          checkOutput("frameStopBit",  stopBit,  1);
          if (haveWant) checkOutput("frameByte", got, want);
        end
        prevLine = 1'b1;
      end else begin
        prevLine = serial[idx];
      end
    end
  endtask

  task automatic doneMonitor(input int idx);
    doneRec_t rec;
    bit haveRec;
    forever begin
      @(negedge clock);
      if (txDone[idx] === 1'b1) begin
        haveRec = 1'b0;
        rec = '{0, 0, 0};
        if (idx == 0 && expDone0.size() > 0) begin rec = expDone0.pop_front(); haveRec = 1'b1; end
        if (idx == 1 && expDone1.size() > 0) begin rec = expDone1.pop_front(); haveRec = 1'b1; end
        checkOutput("doneExpected", haveRec, 1);
        checkOutput("doneBusy", busy[idx], 1);
        if (haveRec) begin
          checkOutput("doneBytesSent",   bytesSent[idx],   rec.bytesSent);
          checkOutput("doneAborted",     aborted[idx],     rec.aborted);
          checkOutput("doneLengthError", lengthError[idx], rec.lengthError);
        end
        doneCount[idx]++;
      end else if (aborted[idx] === 1'b1) begin
        checkOutput("abortedWithoutDone", aborted[idx], 0);
      end
    end
  endtask

  initial lineMonitor(0);
  initial lineMonitor(1);
  initial doneMonitor(0);
  initial doneMonitor(1);

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int seen;
    logic [8*MAX_BYTES-1:0] data;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; txBegin[i] = 1'b0; txData[i] = '0; txLen[i] = '0; abortIn[i] = 1'b0;
      doneCount[i] = 0;
    end
    repeat (3) @(posedge clock);
    checkResetState(0);
    checkResetState(1);
    @(posedge clock); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (3) @(posedge clock);

    $display("[TB] MSB-first and LSB-first three-byte packets");
    data = '0;
    data[23:0] = 24'hA1B2C3;
    applyStimulus(0, data, 3, -1);
    waitPackets(0, 1, 600);
    base = starts1.size();
    applyStimulus(1, data, 3, -1);
    waitPackets(1, 1, 800);
    checkOutput("lsbFrameCount", starts1.size() - base, 3);
    if (starts1.size() - base == 3) begin
      for (int i = 1; i < 3; i++)
        checkOutput("gapStartSpacing", starts1[base + i] - starts1[base + i - 1], 120);
    end

    $display("[TB] zero length and overlong packets");
    applyStimulus(0, randomData(), 0, -1);
    waitPackets(0, 1, 20);
    applyStimulus(0, randomData(), 20, -1);
    waitPackets(0, 1, 14 * 110);

    $display("[TB] abort during the second frame");
    base = starts0.size();
    applyStimulus(0, randomData(), 5, 2);
    for (int c = 0; c < 400 && starts0.size() < base + 2; c++) @(posedge clock);
    checkOutput("secondFrameStarted", (starts0.size() >= base + 2) ? 1 : 0, 1);
    repeat (40) @(posedge clock);
    #1 abortIn[0] = 1'b1;
    @(posedge clock); #1 abortIn[0] = 1'b0;
    waitPackets(0, 1, 300);

    $display("[TB] reset in the middle of the first frame");
    base = starts0.size();
    applyStimulus(0, randomData(), 3, -1);
    for (int c = 0; c < 50 && starts0.size() < base + 1; c++) @(posedge clock);
    repeat (30) @(posedge clock);
    #1 rst[0] = 1'b1;
    @(posedge clock);
    flushInstance(0);
    checkResetState(0);
    @(posedge clock); #1 rst[0] = 1'b0;
    repeat (110) @(posedge clock);
    applyStimulus(0, randomData(), 2, -1);
    waitPackets(0, 1, 400);

    $display("[TB] begin held high across three packets");
    base = starts0.size();
    data = randomData();
    @(posedge clock); #1;
    txBegin[0] = 1'b1; txData[0] = data; txLen[0] = 8'd2;
    for (int p = 0; p < 3; p++) pushExpected(0, data, 2, -1);
    seen = 0;
    for (int c = 0; c < 1000 && seen < 3; c++) begin
      @(posedge clock); #1;
      if (txDone[0] === 1'b1) begin
        seen++;
        if (seen == 3) txBegin[0] = 1'b0;
      end
    end
    txBegin[0] = 1'b0;
    checkOutput("heldBeginPackets", seen, 3);
    repeat (150) @(posedge clock);
    checkOutput("heldBeginFrames", starts0.size() - base, 6);
    if (starts0.size() - base == 6) begin
      checkOutput("packetBoundarySpacing1", starts0[base + 2] - starts0[base + 1], 103);
      checkOutput("packetBoundarySpacing2", starts0[base + 4] - starts0[base + 3], 103);
      checkOutput("inPacketSpacing", (starts0[base + 1] - starts0[base] <= 102) ? 1 : 0, 1);
    end

    $display("[TB] randomized packets");
    for (int r = 0; r < 6; r++) begin
      applyStimulus(r % 2, randomData(), int'($urandom_range(1, 5)), -1);
      waitPackets(r % 2, 1, 5 * 130);
    end

    repeat (200) @(posedge clock);
    checkOutput("pendingFrames0", expFrames0.size(), 0);
    checkOutput("pendingFrames1", expFrames1.size(), 0);
    checkOutput("pendingDone0",   expDone0.size(),   0);
    checkOutput("pendingDone1",   expDone1.size(),   0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
